alu_rr_sched: RTL

Round-robin scheduler that shares one 8-bit, 2-bit-opcode combinational ALU between NUM_REQ requesters. It arbitrates requests, drives registered operands and opcode to the ALU, captures the result, and returns it with the requester ID over a valid/ready response channel. It sits between client engines and the single shared ALU instance. The ALU opcodes are 00 AND, 01 XOR, 10 ADD (mod 256) and 11 SUB (mod 256).

---
 rtl/alu_rr_sched_if.sv | 40 ++++
 rtl/alu_rr_sched.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/alu_rr_sched_if.sv
// Bundles the request, shared-ALU and response signals of the round-robin ALU
// scheduler. The slave modport is the scheduler. The master modport is its
// environment: the requesters, the shared ALU and the response consumer.
interface alu_rr_sched_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned CNT_W   = 16
) ();

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [8*NUM_REQ-1:0] req_a;
  logic [8*NUM_REQ-1:0] req_b;
  logic [2*NUM_REQ-1:0] req_op;

  logic [7:0]           alu_a;
  logic [7:0]           alu_b;
  logic [1:0]           alu_opcode;
  logic [7:0]           alu_result;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [7:0]           rsp_data;
  logic                 rsp_zero;
  logic [CNT_W-1:0]     ops_done;

  modport master (
    output req_valid, req_a, req_b, req_op, alu_result, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_opcode, rsp_valid, rsp_id, rsp_data, rsp_zero,
           ops_done
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, alu_result, rsp_ready,
    output req_ready, alu_a, alu_b, alu_opcode, rsp_valid, rsp_id, rsp_data, rsp_zero,
           ops_done
  );

endinterface

// File: rtl/alu_rr_sched.sv
// Round-robin scheduler that shares one combinational 8-bit ALU between NUM_REQ
// requesters. A grant latches the operands, one cycle is spent in the ALU, and
// the captured result is returned with the owner's index on a valid/ready channel.
module alu_rr_sched #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned CNT_W   = 16
) (
  input logic            clk,
  input logic            rst,
  alu_rr_sched_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [7:0]       alu_a_q, alu_a_d;
  logic [7:0]       alu_b_q, alu_b_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic [7:0]       rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic [CNT_W-1:0] ops_done_q, ops_done_d;

  logic               grant_found;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    cand;
  logic [7:0]         grant_a;
  logic [7:0]         grant_b;
  logic [1:0]         grant_op;
  logic [NUM_REQ-1:0] req_ready;

  // Round-robin search: first valid requester at or after rr_ptr+1, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Operand mux selecting the winner's packed fields.
  always_comb begin
    grant_a  = '0;
    grant_b  = '0;
    grant_op = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        grant_a  = bus.req_a[8*i +: 8];
        grant_b  = bus.req_b[8*i +: 8];
        grant_op = bus.req_op[2*i +: 2];
      end
    end
  end

  // FSM next-state, grant strobe and datapath updates.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_zero_d  = rsp_zero_q;
    ops_done_d  = ops_done_q;
    req_ready   = '0;

    unique case (state_q)
      StIdle: begin
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          alu_a_d              = grant_a;
          alu_b_d              = grant_b;
          alu_op_d             = grant_op;
          rsp_id_d             = grant_idx;
          rr_ptr_d             = grant_idx;
          state_d              = StExec;
        end
      end
      StExec: begin
        rsp_data_d  = bus.alu_result;
        rsp_zero_d  = (bus.alu_result == 8'h00);
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          ops_done_d  = ops_done_q + CNT_W'(1);
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // No acceptance may be signalled while the block is being reset.
    if (rst) begin
      req_ready = '0;
    end
  end

  // State register; reset drops any in-flight operation without a response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= ID_W'(NUM_REQ - 1);
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_zero_q  <= 1'b0;
      ops_done_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_zero_q  <= rsp_zero_d;
      ops_done_q  <= ops_done_d;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_opcode = alu_op_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.ops_done   = ops_done_q;

endmodule
